answer_formatter: RTL

Sits directly downstream of the puzzle solver. It consumes the solver's Done/Error/Answer outputs and converts the binary Answer to decimal with a sequential double-dabble. It then streams the result as ASCII bytes over a valid/ready byte interface, which feeds the board UART transmitter. The output is the decimal digits with leading zeros suppressed, followed by a line feed. If the solver reports an error, the block streams "ERR\n" instead.

---
 rtl/answer_formatter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/answer_formatter.sv
// Converts the solver's binary answer to decimal with a sequential double-dabble
// and streams it as ASCII digits plus LF (or "ERR\n") over a valid/ready byte port.
module answer_formatter #(
  parameter int ANSWER_BITS = 48,
  parameter int DIGITS      = 15
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   SolverDone,
  input  logic                   SolverError,
  input  logic [ANSWER_BITS-1:0] Answer,
  output logic [7:0]             TxData,
  output logic                   TxValid,
  input  logic                   TxReady,
  output logic                   Busy,
  output logic                   Sent
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(ANSWER_BITS + 1);
  localparam int IDX_W = ($clog2(DIGITS) < 2) ? 2 : $clog2(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_EMIT, S_DONE} state_t;

  state_t                 r_state, w_state;
  logic                   r_hist;
  logic [ANSWER_BITS-1:0] r_shift, w_shift;
  logic [BCD_W-1:0]       r_bcd, w_bcd;
  logic [CNT_W-1:0]       r_cnt, w_cnt;
  logic [IDX_W-1:0]       r_idx, w_idx;
  logic                   r_err, w_err;
  logic                   r_lf, w_lf;
  logic [7:0]             r_txdata, w_txdata;
  logic                   r_txvalid, w_txvalid;
  logic                   r_sent, w_sent;

  logic                   w_lvl;
  logic                   w_trig;
  logic [BCD_W-1:0]       w_bcd_adj;
  logic [BCD_W-1:0]       w_bcd_step;
  logic [IDX_W-1:0]       w_msd;
  logic [IDX_W-1:0]       w_idx_dn;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int d = 0; d < DIGITS; d++) begin
      if (b[4*d +: 4] >= 4'd5) r[4*d +: 4] = b[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Highest nonzero digit; an all-zero value reports digit 0 so one '0' is sent.
  function automatic logic [IDX_W-1:0] msd(input logic [BCD_W-1:0] b);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (b[4*d +: 4] != 4'd0) idx = IDX_W'(d);
    end
    return idx;
  endfunction

  function automatic logic [3:0] get_digit(input logic [BCD_W-1:0] b, input logic [IDX_W-1:0] idx);
    return b[4*int'(idx) +: 4];
  endfunction

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  assign w_lvl      = SolverDone | SolverError;
  assign w_trig     = w_lvl & ~r_hist;
  assign w_bcd_adj  = add3(r_bcd);
  assign w_bcd_step = {w_bcd_adj[BCD_W-2:0], r_shift[ANSWER_BITS-1]};
  assign w_msd      = msd(w_bcd_step);
  assign w_idx_dn   = r_idx - IDX_W'(1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_hist    <= 1'b0;
      r_shift   <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_lf      <= 1'b0;
      r_txdata  <= 8'h00;
      r_txvalid <= 1'b0;
      r_sent    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_hist    <= w_lvl;
      r_shift   <= w_shift;
      r_bcd     <= w_bcd;
      r_cnt     <= w_cnt;
      r_idx     <= w_idx;
      r_err     <= w_err;
      r_lf      <= w_lf;
      r_txdata  <= w_txdata;
      r_txvalid <= w_txvalid;
      r_sent    <= w_sent;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_shift   = r_shift;
    w_bcd     = r_bcd;
    w_cnt     = r_cnt;
    w_idx     = r_idx;
    w_err     = r_err;
    w_lf      = r_lf;
    w_txdata  = r_txdata;
    w_txvalid = r_txvalid;
    w_sent    = r_sent;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_lf = 1'b0;
          if (SolverError) begin
            w_err     = 1'b1;
            w_idx     = '0;
            w_txdata  = 8'h45;
            w_txvalid = 1'b1;
            w_state   = S_EMIT;
          end else begin
            w_err   = 1'b0;
            w_shift = Answer;
            w_bcd   = '0;
            w_cnt   = CNT_W'(ANSWER_BITS);
            w_state = S_CONVERT;
          end
        end
      end
      S_CONVERT: begin
        w_bcd   = w_bcd_step;
        w_shift = {r_shift[ANSWER_BITS-2:0], 1'b0};
        w_cnt   = r_cnt - CNT_W'(1);
        // The last shift also presents the first digit so TxValid rises on EMIT entry.
        if (r_cnt == CNT_W'(1)) begin
          w_idx     = w_msd;
          w_txdata  = to_ascii(get_digit(w_bcd_step, w_msd));
          w_txvalid = 1'b1;
          w_state   = S_EMIT;
        end
      end
      S_EMIT: begin
        if (r_txvalid && TxReady) begin
          if (r_lf) begin
            w_txvalid = 1'b0;
            w_txdata  = 8'h00;
            w_sent    = 1'b1;
            w_state   = S_DONE;
          end else if (r_err) begin
            if (r_idx == IDX_W'(2)) begin
              w_txdata = 8'h0A;
              w_lf     = 1'b1;
            end else begin
              w_idx    = r_idx + IDX_W'(1);
              w_txdata = 8'h52;
            end
          end else if (r_idx == '0) begin
            w_txdata = 8'h0A;
            w_lf     = 1'b1;
          end else begin
            w_idx    = w_idx_dn;
            w_txdata = to_ascii(get_digit(r_bcd, w_idx_dn));
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign TxData  = r_txdata;
  assign TxValid = r_txvalid;
  assign Busy    = (r_state == S_CONVERT) || (r_state == S_EMIT);
  assign Sent    = r_sent;

endmodule
